mem_access: RTL and testbench

Memory-access stage of the 64-bit pipeline, directly downstream of the execute-stage ALU. It consumes the ALU result (a writeback value or an effective address) plus the store data and memory opcode. Loads and stores are issued on the data bus with a valid/addr_ok/data_ok handshake, and load data is aligned and extended. Exactly one writeback record per accepted instruction is handed to the writeback stage.

---
 rtl/mem_access_if.sv | 55 +++++
 rtl/mem_access.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Purpose: bundles the execute-side, data-bus and writeback signals of the
//          memory-access stage.
// Ports (by group):
//   ex_*    : instruction from execute (valid/ready handshake)
//   dreq_*  : data-bus request issued by the stage
//   dresp_* : data-bus response (addr_ok / data_ok / load data)
//   wb_*    : one-cycle writeback record toward the writeback stage
// Modports: slave = the mem_access stage, master = its environment.
interface mem_access_if;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned STRB_W = 8;

  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_result;
  logic [XLEN-1:0]   ex_store_data;
  logic [OP_W-1:0]   ex_mem_op;
  logic [RIDX_W-1:0] ex_rd;
  logic              ex_wen;

  logic              dreq_valid;
  logic [XLEN-1:0]   dreq_addr;
  logic [SIZE_W-1:0] dreq_size;
  logic [STRB_W-1:0] dreq_strobe;
  logic [XLEN-1:0]   dreq_data;

  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [XLEN-1:0]   dresp_data;

  logic              wb_valid;
  logic [RIDX_W-1:0] wb_rd;
  logic              wb_wen;
  logic [XLEN-1:0]   wb_data;
  logic              wb_misalign;

  modport slave (
    input  ex_valid, ex_result, ex_store_data, ex_mem_op, ex_rd, ex_wen,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output ex_ready,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output wb_valid, wb_rd, wb_wen, wb_data, wb_misalign
  );

  modport master (
    output ex_valid, ex_result, ex_store_data, ex_mem_op, ex_rd, ex_wen,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  ex_ready,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  wb_valid, wb_rd, wb_wen, wb_data, wb_misalign
  );
endinterface

// File: rtl/mem_access.sv
// Purpose: memory-access pipeline stage. Passes non-memory results through,
//          issues aligned loads/stores on the data bus, aligns/extends load
//          data and emits exactly one writeback record per accepted op.
//          Misaligned accesses produce a fault record without a bus request.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : mem_access_if.slave (ex_*, dreq_*, dresp_*, wb_* groups)
module mem_access (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);
  localparam int unsigned XLEN   = 64;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned STRB_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_d;

  logic              dreq_valid_q, dreq_valid_d;
  logic [XLEN-1:0]   dreq_addr_q, dreq_addr_d;
  logic [SIZE_W-1:0] dreq_size_q, dreq_size_d;
  logic [STRB_W-1:0] dreq_strobe_q, dreq_strobe_d;
  logic [XLEN-1:0]   dreq_data_q, dreq_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RIDX_W-1:0] wb_rd_q, wb_rd_d;
  logic              wb_wen_q, wb_wen_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              wb_misalign_q, wb_misalign_d;

  // Latched attributes of the in-flight access
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic              wen_q, wen_d;
  logic              store_q, store_d;
  logic              signed_q, signed_d;

  // Opcode decode
  logic       op_mem, op_store, op_signed;
  logic [1:0] op_size;
  logic [2:0] ex_off;
  logic       aligned;

  assign ex_off = bus.ex_result[2:0];

  always_comb begin
    op_mem    = 1'b1;
    op_store  = 1'b0;
    op_signed = 1'b0;
    op_size   = 2'd0;
    case (bus.ex_mem_op)
      4'd1:    begin op_size = 2'd0; op_signed = 1'b1; end
      4'd2:    begin op_size = 2'd1; op_signed = 1'b1; end
      4'd3:    begin op_size = 2'd2; op_signed = 1'b1; end
      4'd4:    op_size = 2'd3;
      4'd5:    op_size = 2'd0;
      4'd6:    op_size = 2'd1;
      4'd7:    op_size = 2'd2;
      4'd8:    begin op_size = 2'd0; op_store = 1'b1; end
      4'd9:    begin op_size = 2'd1; op_store = 1'b1; end
      4'd10:   begin op_size = 2'd2; op_store = 1'b1; end
      4'd11:   begin op_size = 2'd3; op_store = 1'b1; end
      default: op_mem = 1'b0;
    endcase
  end

  // Offset must be a multiple of the access size
  always_comb begin
    case (op_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = (ex_off[0] == 1'b0);
      2'd2:    aligned = (ex_off[1:0] == 2'b00);
      default: aligned = (ex_off == 3'b000);
    endcase
  end

  // Byte-lane mask for the access size, before shifting to the offset
  logic [STRB_W-1:0] size_mask;
  always_comb begin
    case (op_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Load alignment and extension, using the held request address/size
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_value;
  always_comb begin
    ld_shift = bus.dresp_data >> {dreq_addr_q[2:0], 3'b000};
    case (dreq_size_q[1:0])
      2'd0:    ld_value = signed_q ? {{56{ld_shift[7]}},  ld_shift[7:0]}
                                   : {56'd0, ld_shift[7:0]};
      2'd1:    ld_value = signed_q ? {{48{ld_shift[15]}}, ld_shift[15:0]}
                                   : {48'd0, ld_shift[15:0]};
      2'd2:    ld_value = signed_q ? {{32{ld_shift[31]}}, ld_shift[31:0]}
                                   : {32'd0, ld_shift[31:0]};
      default: ld_value = ld_shift;
    endcase
  end

  assign bus.ex_ready = (state == IDLE);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    dreq_valid_d  = dreq_valid_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_size_d   = dreq_size_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_wen_d      = wb_wen_q;
    wb_data_d     = wb_data_q;
    wb_misalign_d = wb_misalign_q;
    rd_d          = rd_q;
    wen_d         = wen_q;
    store_d       = store_q;
    signed_d      = signed_q;

    case (state)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!op_mem) begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = bus.ex_rd;
            wb_wen_d      = bus.ex_wen;
            wb_data_d     = bus.ex_result;
            wb_misalign_d = 1'b0;
          end else if (!aligned) begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = bus.ex_rd;
            wb_wen_d      = 1'b0;
            wb_data_d     = bus.ex_result;
            wb_misalign_d = 1'b1;
          end else begin
            state_d       = REQ;
            dreq_valid_d  = 1'b1;
            dreq_addr_d   = bus.ex_result;
            dreq_size_d   = {1'b0, op_size};
            dreq_strobe_d = op_store ? STRB_W'(size_mask << ex_off) : '0;
            dreq_data_d   = op_store ? XLEN'(bus.ex_store_data << {ex_off, 3'b000}) : '0;
            rd_d          = bus.ex_rd;
            wen_d         = bus.ex_wen;
            store_d       = op_store;
            signed_d      = op_signed;
          end
        end
      end
      REQ: begin
        if (bus.dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          state_d      = bus.dresp_data_ok ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.dresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion record (from REQ with same-cycle data_ok, or from WAIT)
    if ((state == REQ && bus.dresp_addr_ok && bus.dresp_data_ok) ||
        (state == WAIT && bus.dresp_data_ok)) begin
      wb_valid_d    = 1'b1;
      wb_rd_d       = rd_q;
      wb_misalign_d = 1'b0;
      wb_wen_d      = store_q ? 1'b0 : wen_q;
      wb_data_d     = store_q ? '0 : ld_value;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_wen_q      <= 1'b0;
      wb_data_q     <= '0;
      wb_misalign_q <= 1'b0;
      rd_q          <= '0;
      wen_q         <= 1'b0;
      store_q       <= 1'b0;
      signed_q      <= 1'b0;
    end else begin
      state         <= state_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_size_q   <= dreq_size_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_wen_q      <= wb_wen_d;
      wb_data_q     <= wb_data_d;
      wb_misalign_q <= wb_misalign_d;
      rd_q          <= rd_d;
      wen_q         <= wen_d;
      store_q       <= store_d;
      signed_q      <= signed_d;
    end
  end

  assign bus.dreq_valid  = dreq_valid_q;
  assign bus.dreq_addr   = dreq_addr_q;
  assign bus.dreq_size   = dreq_size_q;
  assign bus.dreq_strobe = dreq_strobe_q;
  assign bus.dreq_data   = dreq_data_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_wen      = wb_wen_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_misalign = wb_misalign_q;
endmodule

// File: tb/tb_mem_access.sv
// Purpose: directed self-checking bench for mem_access.
// Ports: none (top level); drives a mem_access_if instance into the DUT.
module tb_mem_access;
  logic clk;
  logic reset;
  int   total;
  int   passes;

  mem_access_if bus ();

  mem_access dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
  endtask

  // Present one instruction for a single accepting edge
  task automatic issue(input logic [3:0] op, input logic [63:0] addr,
                       input logic [63:0] sdata, input logic [4:0] rd,
                       input logic wen);
    bus.ex_valid      = 1'b1;
    bus.ex_mem_op     = op;
    bus.ex_result     = addr;
    bus.ex_store_data = sdata;
    bus.ex_rd         = rd;
    bus.ex_wen        = wen;
    step();
    bus.ex_valid      = 1'b0;
  endtask

  task automatic resp(input logic aok, input logic dok, input logic [63:0] data);
    bus.dresp_addr_ok = aok;
    bus.dresp_data_ok = dok;
    bus.dresp_data    = data;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dreq_valid"},  64'(bus.dreq_valid),  64'd0);
    chk({tag, ".dreq_addr"},   bus.dreq_addr,        64'd0);
    chk({tag, ".dreq_size"},   64'(bus.dreq_size),   64'd0);
    chk({tag, ".dreq_strobe"}, 64'(bus.dreq_strobe), 64'd0);
    chk({tag, ".dreq_data"},   bus.dreq_data,        64'd0);
    chk({tag, ".wb_valid"},    64'(bus.wb_valid),    64'd0);
    chk({tag, ".wb_rd"},       64'(bus.wb_rd),       64'd0);
    chk({tag, ".wb_wen"},      64'(bus.wb_wen),      64'd0);
    chk({tag, ".wb_data"},     bus.wb_data,          64'd0);
    chk({tag, ".wb_misalign"}, 64'(bus.wb_misalign), 64'd0);
    chk({tag, ".ex_ready"},    64'(bus.ex_ready),    64'd1);
  endtask

  initial begin
    total  = 0;
    passes = 0;
    reset  = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_mem_op = '0; bus.ex_result = '0;
    bus.ex_store_data = '0; bus.ex_rd = '0; bus.ex_wen = 1'b0;
    resp(1'b0, 1'b0, 64'd0);

    // Reset
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b1;

    // NONE x3 back-to-back
    bus.ex_valid = 1'b1; bus.ex_mem_op = 4'd0; bus.ex_result = 64'h1234;
    bus.ex_rd = 5'd5; bus.ex_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("none%0d.wb_valid", i), 64'(bus.wb_valid), 64'd1);
      chk($sformatf("none%0d.wb_data", i),  bus.wb_data,       64'h1234);
      chk($sformatf("none%0d.wb_rd", i),    64'(bus.wb_rd),    64'd5);
      chk($sformatf("none%0d.wb_wen", i),   64'(bus.wb_wen),   64'd1);
      chk($sformatf("none%0d.ex_ready", i), 64'(bus.ex_ready), 64'd1);
    end
    bus.ex_valid = 1'b0;
    step();
    chk("none.after.wb_valid", 64'(bus.wb_valid), 64'd0);

    // LD with addr_ok after 2 extra cycles, data_ok 3 cycles later
    issue(4'd4, 64'h8000_0008, 64'd0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ld.req%0d.dreq_valid", i), 64'(bus.dreq_valid), 64'd1);
      chk($sformatf("ld.req%0d.dreq_size", i),  64'(bus.dreq_size),  64'd3);
      chk($sformatf("ld.req%0d.dreq_addr", i),  bus.dreq_addr,       64'h8000_0008);
      chk($sformatf("ld.req%0d.ex_ready", i),   64'(bus.ex_ready),   64'd0);
      if (i == 2) resp(1'b1, 1'b0, 64'd0);
      step();
    end
    resp(1'b0, 1'b0, 64'd0);
    chk("ld.wait.dreq_valid", 64'(bus.dreq_valid), 64'd0);
    chk("ld.wait.wb_valid",   64'(bus.wb_valid),   64'd0);
    step();
    chk("ld.wait2.wb_valid",  64'(bus.wb_valid),   64'd0);
    step();
    resp(1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    resp(1'b0, 1'b0, 64'd0);
    chk("ld.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("ld.wb_data",  bus.wb_data,       64'hDEAD_BEEF_CAFE_F00D);
    chk("ld.wb_wen",   64'(bus.wb_wen),   64'd1);
    chk("ld.wb_rd",    64'(bus.wb_rd),    64'd7);
    chk("ld.ex_ready", 64'(bus.ex_ready), 64'd1);
    step();
    chk("ld.after.wb_valid", 64'(bus.wb_valid), 64'd0);

    // LB sign-extends byte 3
    issue(4'd1, 64'h8000_1003, 64'd0, 5'd9, 1'b1);
    chk("lb.dreq_size",   64'(bus.dreq_size),   64'd0);
    chk("lb.dreq_strobe", 64'(bus.dreq_strobe), 64'd0);
    resp(1'b1, 1'b1, 64'h0000_0000_80FF_0000);
    step();
    resp(1'b0, 1'b0, 64'd0);
    chk("lb.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("lb.wb_data",  bus.wb_data,       64'hFFFF_FFFF_FFFF_FF80);

    // LBU zero-extends the same byte
    issue(4'd5, 64'h8000_1003, 64'd0, 5'd9, 1'b1);
    resp(1'b1, 1'b1, 64'h0000_0000_80FF_0000);
    step();
    resp(1'b0, 1'b0, 64'd0);
    chk("lbu.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("lbu.wb_data",  bus.wb_data,       64'h80);

    // SW at offset 4: lane shift and strobe
    issue(4'd10, 64'h8000_0004, 64'h1122_3344_5566_7788, 5'd3, 1'b1);
    chk("sw.dreq_valid",  64'(bus.dreq_valid),  64'd1);
    chk("sw.dreq_data",   bus.dreq_data,        64'h5566_7788_0000_0000);
    chk("sw.dreq_strobe", 64'(bus.dreq_strobe), 64'hF0);
    chk("sw.dreq_size",   64'(bus.dreq_size),   64'd2);
    resp(1'b1, 1'b0, 64'd0);
    step();
    resp(1'b0, 1'b1, 64'd0);
    chk("sw.wait.wb_valid", 64'(bus.wb_valid), 64'd0);
    step();
    resp(1'b0, 1'b0, 64'd0);
    chk("sw.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("sw.wb_wen",   64'(bus.wb_wen),   64'd0);
    chk("sw.wb_data",  bus.wb_data,       64'd0);
    chk("sw.wb_rd",    64'(bus.wb_rd),    64'd3);

    // Misaligned LH
    issue(4'd2, 64'h8000_0001, 64'd0, 5'd11, 1'b1);
    chk("lh.mis.dreq_valid",  64'(bus.dreq_valid),  64'd0);
    chk("lh.mis.wb_valid",    64'(bus.wb_valid),    64'd1);
    chk("lh.mis.wb_misalign", 64'(bus.wb_misalign), 64'd1);
    chk("lh.mis.wb_wen",      64'(bus.wb_wen),      64'd0);
    chk("lh.mis.wb_data",     bus.wb_data,          64'h8000_0001);
    chk("lh.mis.wb_rd",       64'(bus.wb_rd),       64'd11);
    chk("lh.mis.ex_ready",    64'(bus.ex_ready),    64'd1);

    // LW with addr_ok & data_ok in the first REQ cycle
    issue(4'd3, 64'h8000_0010, 64'd0, 5'd12, 1'b1);
    chk("lw.dreq_valid", 64'(bus.dreq_valid), 64'd1);
    resp(1'b1, 1'b1, 64'h1234_5678_8000_0001);
    step();
    resp(1'b0, 1'b0, 64'd0);
    chk("lw.wb_valid",    64'(bus.wb_valid),    64'd1);
    chk("lw.wb_data",     bus.wb_data,          64'hFFFF_FFFF_8000_0001);
    chk("lw.wb_misalign", 64'(bus.wb_misalign), 64'd0);
    chk("lw.ex_ready",    64'(bus.ex_ready),    64'd1);
    chk("lw.dreq_valid0", 64'(bus.dreq_valid),  64'd0);

    // Reset during WAIT abandons the access
    issue(4'd4, 64'h8000_0020, 64'd0, 5'd13, 1'b1);
    resp(1'b1, 1'b0, 64'd0);
    step();
    resp(1'b0, 1'b0, 64'd0);
    chk("rstw.wait.ex_ready", 64'(bus.ex_ready), 64'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_all_zero("rstw");
    // Stray data_ok while idle produces nothing
    resp(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    resp(1'b0, 1'b0, 64'd0);
    chk("stray.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("stray.ex_ready", 64'(bus.ex_ready), 64'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
